// File: rtl/onehot_cnt_encoder_pkg.sv
// Shared definitions for the count path: count width, count constants,
// the select-FSM state type and the one-hot-to-count helper. The helper is
// also usable from testbenches.
package onehot_cnt_encoder_pkg;

   localparam int CNT_W = 3;

   localparam logic [CNT_W-1:0] CNT_NONE = 3'd0;
   localparam logic [CNT_W-1:0] CNT_MIN  = 3'd1;
   localparam logic [CNT_W-1:0] CNT_MAX  = 3'd6;

   // One select line per legal count value.
   localparam int SEL_W = int'(CNT_MAX);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HELD = 1'b1
   } state_e;

   // Bit i maps to count i+1. Anything that is not exactly one-hot
   // (including all-zero) maps to CNT_NONE.
   function automatic logic [CNT_W-1:0] onehot_to_cnt(input logic [SEL_W-1:0] oh);
      logic [CNT_W-1:0] c;
      c = CNT_NONE;
      if ($onehot(oh)) begin
         for (int i = 0; i < SEL_W; i++) begin
            if (oh[i]) c = CNT_W'(i) + CNT_MIN;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/onehot_sync_debounce.sv
// Two-flop synchroniser plus stability counter for a vector of asynchronous
// lines. The debounced vector d loads the synchronised vector once it has
// been seen unchanged for DEBOUNCE_CYCLES consecutive samples.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   raw_i      raw asynchronous lines
//   upd_o      d loads upd_val_o at the next edge (combinational strobe)
//   upd_val_o  synchronised vector s, the value d is about to load
//   d_o        current debounced vector
module onehot_sync_debounce #(
   parameter int W               = 6,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw_i,
   output logic         upd_o,
   output logic [W-1:0] upd_val_o,
   output logic [W-1:0] d_o
);

   localparam logic [7:0] STB_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0] sync1_q;
   logic [W-1:0] s_q;
   logic [W-1:0] p_q;
   logic [W-1:0] d_q;
   logic [W-1:0] d_d;
   logic [7:0]   stb_q;
   logic [7:0]   stb_d;
   logic         same;
   logic         upd;

   always_comb begin
      same  = (s_q == p_q);
      upd   = same && (stb_q == STB_MAX);
      stb_d = stb_q;
      d_d   = d_q;
      // Any mismatch restarts the window; otherwise count up and saturate
      // so a long-held vector keeps reloading the same value harmlessly.
      if (!same) begin
         stb_d = '0;
      end else if (stb_q != STB_MAX) begin
         stb_d = stb_q + 8'd1;
      end
      if (upd) d_d = s_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         s_q     <= '0;
         p_q     <= '0;
         stb_q   <= '0;
         d_q     <= '0;
      end else begin
         sync1_q <= raw_i;
         s_q     <= sync1_q;
         p_q     <= s_q;
         stb_q   <= stb_d;
         d_q     <= d_d;
      end
   end

   assign upd_o     = upd;
   assign upd_val_o = s_q;
   assign d_o       = d_q;

endmodule

// File: rtl/onehot_cnt_encoder.sv
// Encodes six asynchronous select lines into the shared 1..6 count format
// and hands each accepted code once to the game controller.
//
// Handshake: cnt_out is transferred on every rising edge where
// cnt_valid && cnt_ready. While cnt_valid is high, cnt_out is held stable
// until that edge; cnt_ready has no effect while cnt_valid is low.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   in_onehot    raw select lines, bit i means count i+1
//   cnt_out      encoded count 1..6, 0 when nothing is held
//   cnt_valid    cnt_out holds an undelivered code
//   cnt_ready    consumer accepts cnt_out
//   err_multi    1-cycle pulse: debounced press had several bits set
//   overrun      1-cycle pulse: legal press dropped, previous code pending
//   fsm_state_o  debug view of the press FSM state
module onehot_cnt_encoder
   import onehot_cnt_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] in_onehot,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             err_multi,
   output logic             overrun,
   output state_e           fsm_state_o
);

   logic             upd;
   logic [SEL_W-1:0] upd_val;
   logic [SEL_W-1:0] d;

   onehot_sync_debounce #(
      .W               (SEL_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (in_onehot),
      .upd_o     (upd),
      .upd_val_o (upd_val),
      .d_o       (d)
   );

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             valid_q;
   logic             err_q;
   logic             ovr_q;

   logic             press_ev;
   logic             rel_ev;
   logic [CNT_W-1:0] press_code;

   // Press/release are taken from the load strobe so the press is acted on
   // in the same edge that d takes its new value.
   always_comb begin
      press_ev   = (state_q == S_IDLE) && upd && (upd_val != '0) && (d == '0);
      rel_ev     = (state_q == S_HELD) && upd && (upd_val == '0) && (d != '0);
      press_code = onehot_to_cnt(upd_val);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_NONE;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         ovr_q <= 1'b0;
         if (valid_q && cnt_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= CNT_NONE;
         end
         case (state_q)
            S_IDLE: begin
               if (press_ev) begin
                  // Multi-hot presses still enter S_HELD so a release is
                  // required before the next press is considered.
                  state_q <= S_HELD;
                  if (press_code != CNT_NONE) begin
                     // A code accepted this very edge frees the slot; the
                     // new load overrides the clear above.
                     if (!valid_q || cnt_ready) begin
                        cnt_q   <= press_code;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_HELD: begin
               if (rel_ev) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cnt_out     = cnt_q;
   assign cnt_valid   = valid_q;
   assign err_multi   = err_q;
   assign overrun     = ovr_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_onehot_cnt_encoder.sv
module tb_onehot_cnt_encoder;
   import onehot_cnt_encoder_pkg::*;

   localparam int DC = 4;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst_n;
   logic [5:0]       in_onehot;
   logic             cnt_ready;
   logic [CNT_W-1:0] cnt_out;
   logic             cnt_valid;
   logic             err_multi;
   logic             overrun;
   state_e           fsm_state;

   always #5 clk = ~clk;

   onehot_cnt_encoder #(
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_onehot   (in_onehot),
      .cnt_out     (cnt_out),
      .cnt_valid   (cnt_valid),
      .cnt_ready   (cnt_ready),
      .err_multi   (err_multi),
      .overrun     (overrun),
      .fsm_state_o (fsm_state)
   );

   // ---------------- scoreboard ----------------
   int             checks = 0;
   int             passed = 0;
   logic [CNT_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
      checks++;
      assert (obs === want) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
   endtask

   // ---------------- reference model ----------------
   // Works on the history of raw input values sampled at each edge: a press
   // is recognised when the raw value seen DC+1 edges in a row (ending two
   // edges ago, the synchroniser depth) is constant and no reset intervened.
   logic [5:0]       hist [0:8191];
   int               edge_n   = 8;
   int               rst_edge = 8;
   logic             e_valid  = 1'b0;
   logic [CNT_W-1:0] e_cnt    = '0;
   logic             e_err    = 1'b0;
   logic             e_ovr    = 1'b0;
   logic             m_held   = 1'b0;

   function automatic void model_edge(input logic rst_v, input logic [5:0] in_v,
                                      input logic rdy_v);
      logic [5:0] v;
      logic       upd;
      logic       was_valid;
      int         ones;
      int         pos;
      hist[edge_n] = in_v;
      e_err = 1'b0;
      e_ovr = 1'b0;
      if (!rst_v) begin
         rst_edge         = edge_n;
         hist[edge_n - 2] = '0;
         hist[edge_n - 1] = '0;
         hist[edge_n]     = '0;
         e_valid          = 1'b0;
         e_cnt            = '0;
         m_held           = 1'b0;
         exp_q.delete();
         return;
      end
      v   = hist[edge_n - 2];
      upd = (edge_n - DC + 1 > rst_edge);
      if (upd) begin
         for (int k = edge_n - DC - 2; k < edge_n - 2; k++)
            if (hist[k] !== v) upd = 1'b0;
      end
      was_valid = e_valid;
      if (e_valid && rdy_v) begin
         e_valid = 1'b0;
         e_cnt   = '0;
      end
      if (upd && !m_held && v != 6'd0) begin
         m_held = 1'b1;
         ones   = 0;
         pos    = 0;
         for (int b = 0; b < 6; b++) if (v[b]) begin ones++; pos = b + 1; end
         if (ones == 1) begin
            if (!was_valid || rdy_v) begin
               e_valid = 1'b1;
               e_cnt   = CNT_W'(pos);
               exp_q.push_back(CNT_W'(pos));
            end else begin
               e_ovr = 1'b1;
            end
         end else begin
            e_err = 1'b1;
         end
      end else if (upd && m_held && v == 6'd0) begin
         m_held = 1'b0;
      end
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic rst_v, input logic [5:0] in_v, input logic rdy_v);
      logic             dv;
      logic [CNT_W-1:0] dc;
      logic [7:0]       want;
      rst_n     = rst_v;
      in_onehot = in_v;
      cnt_ready = rdy_v;
      dv = cnt_valid;
      dc = cnt_out;
      if (rst_v && dv && rdy_v) begin
         want = (exp_q.size() > 0) ? 8'(exp_q.pop_front()) : 8'hff;
         check("delivered_code", 8'(dc), want);
      end
      @(posedge clk);
      edge_n++;
      model_edge(rst_v, in_v, rdy_v);
      #1;
      check("cnt_out",   8'(cnt_out),   8'(e_cnt));
      check("cnt_valid", 8'(cnt_valid), 8'(e_valid));
      check("err_multi", 8'(err_multi), 8'(e_err));
      check("overrun",   8'(overrun),   8'(e_ovr));
      check("fsm_state", 8'(fsm_state), m_held ? 8'(S_HELD) : 8'(S_IDLE));
   endtask

   task automatic hold(input logic rst_v, input logic [5:0] in_v, input logic rdy_v,
                       input int n);
      for (int i = 0; i < n; i++) step(rst_v, in_v, rdy_v);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int         first;
      logic [5:0] val;
      int         len;
      rst_n     = 1'b0;
      in_onehot = '0;
      cnt_ready = 1'b0;

      // Reset state.
      hold(1'b0, 6'b0, 1'b0, 2);

      // Single legal press with consumer ready: code 3 at edge DC+3, once.
      first = 0;
      for (int i = 1; i <= 14; i++) begin
         step(1'b1, 6'b000100, 1'b1);
         if (cnt_valid === 1'b1 && first == 0) begin
            first = i;
            check("t1_code", 8'(cnt_out), 8'd3);
         end
      end
      check("t1_latency", 8'(first), 8'(DC + 3));
      hold(1'b1, 6'b0, 1'b1, 10);

      // Code 6 held pending while consumer stalls, then one accept.
      hold(1'b1, 6'b100000, 1'b0, 20);
      check("t2_pending_code", 8'(cnt_out), 8'd6);
      step(1'b1, 6'b100000, 1'b1);
      check("t2_after_accept", 8'(cnt_valid), 8'd0);
      hold(1'b1, 6'b100000, 1'b0, 3);
      hold(1'b1, 6'b0, 1'b0, 10);

      // Multi-hot press, release, then a legal press of code 1.
      hold(1'b1, 6'b000011, 1'b0, 12);
      hold(1'b1, 6'b0, 1'b0, 10);
      hold(1'b1, 6'b000001, 1'b0, 12);
      check("t3_code", 8'(cnt_out), 8'd1);
      step(1'b1, 6'b000001, 1'b1);
      hold(1'b1, 6'b0, 1'b0, 10);

      // Short glitch never reaches the debounced vector.
      hold(1'b1, 6'b001000, 1'b0, 2);
      hold(1'b1, 6'b0, 1'b0, 10);
      check("t4_no_valid", 8'(cnt_valid), 8'd0);

      // Overrun: code 2 pending, second legal press is dropped.
      hold(1'b1, 6'b000010, 1'b0, 10);
      hold(1'b1, 6'b0, 1'b0, 8);
      hold(1'b1, 6'b010000, 1'b0, 10);
      check("t5_code_kept", 8'(cnt_out), 8'd2);
      step(1'b1, 6'b010000, 1'b1);
      hold(1'b1, 6'b0, 1'b0, 10);

      // Reset while a code is pending and the button is held.
      hold(1'b1, 6'b000100, 1'b0, 10);
      step(1'b0, 6'b000100, 1'b0);
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 6'b000100, 1'b0);
         if (cnt_valid === 1'b1 && first == 0) first = i;
      end
      check("t6_relatency", 8'(first), 8'(DC + 3));
      hold(1'b1, 6'b000100, 1'b1, 1);
      hold(1'b1, 6'b0, 1'b0, 10);

      // Randomised segments: idle, legal, multi-hot, and short glitches.
      for (int seg = 0; seg < 60; seg++) begin
         case ($urandom_range(0, 3))
            0:       val = 6'b0;
            1:       val = 6'(1 << $urandom_range(0, 5));
            2:       val = 6'($urandom_range(1, 63));
            default: val = 6'(1 << $urandom_range(0, 5));
         endcase
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++)
            step(($urandom_range(0, 99) != 0), val, ($urandom_range(0, 2) == 0));
      end

      // Drain: everything the model expected must have been delivered.
      hold(1'b1, 6'b0, 1'b1, 14);
      check("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/onehot_cnt_encoder.md
Name: onehot_cnt_encoder

Overview:
- Inverse of the 3-bit count to 6-line one-hot decoder in the dice/counter path.
- Takes six asynchronous select lines (player buttons / face switches) and encodes them into the shared count format (1..6).
- Synchronises and debounces the lines, rejects illegal multi-hot presses, and delivers each accepted code once over a valid/ready handshake to the game controller.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required before a vector is accepted (legal range 2..255).
- CNT_W, 3, width of the encoded count; fixed by the count format.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- in_onehot  input  6  raw asynchronous select lines; bit i means count value i+1.
- cnt_out  output  3  encoded count, 1..6; 0 when nothing is held.
- cnt_valid  output  1  cnt_out holds an undelivered code.
- cnt_ready  input  1  consumer accepts cnt_out when cnt_valid && cnt_ready at a clock edge.
- err_multi  output  1  one-cycle pulse: debounced press had more than one bit set.
- overrun  output  1  one-cycle pulse: legal press dropped because the previous code was still undelivered.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Sync flops, debounce counter and debounced vector are cleared to 0.
  - FSM goes to S_IDLE.
  - cnt_out=0, cnt_valid=0, err_multi=0, overrun=0.
  - Reset mid-press discards everything. After release of reset, a still-held button is seen as a new press once debounced.
- Synchroniser: two-flop chain on all 6 bits; its output is s.
- Debounce:
  - Register p holds the previous s; stb_cnt is 8 bits.
  - If s != p, stb_cnt is cleared to 0.
  - If s == p, stb_cnt increments, saturating at DEBOUNCE_CYCLES-1.
  - The debounced vector d loads s on the cycle stb_cnt == DEBOUNCE_CYCLES-1 and s == p.
- FSM:
  - S_IDLE to S_HELD: when d becomes non-zero. Evaluated on the cycle d is loaded (event "press").
  - S_HELD to S_IDLE: when d becomes 6'b0.
  - Any change of d while in S_HELD (for example a second button added) is ignored. There is no re-press without a full release.
- Press event:
  - Exactly one bit i set: the code i+1 is a legal press.
    - If cnt_valid==0, or cnt_valid && cnt_ready in the same cycle: cnt_out <= i+1 and cnt_valid <= 1 next cycle.
    - Otherwise cnt_out and cnt_valid are unchanged and overrun pulses for 1 cycle.
  - Two or more bits set: err_multi pulses for 1 cycle. No output update. FSM still enters S_HELD.
- Handshake:
  - cnt_valid stays high and cnt_out stays stable until the cnt_valid && cnt_ready edge.
  - At that edge cnt_valid <= 0 and cnt_out <= 0, unless a legal press loads in the same cycle. The load wins.
  - cnt_ready while cnt_valid==0 has no effect.
- Latency: from the first clock edge that samples a new stable in_onehot value to cnt_valid high = DEBOUNCE_CYCLES+3 edges (7 at default).
- Glitch rule: any sample mismatch restarts the debounce window. A glitch shorter than DEBOUNCE_CYCLES never changes d.
- Encoding must map exactly onto the decoder: bit0 to 3'b001 through bit5 to 3'b110. Codes 0 and 7 are never emitted with cnt_valid=1.

Decomposition:
- Shared package holds:
  - CNT_W.
  - Count constants CNT_NONE=0 and CNT_MIN=1 through CNT_MAX=6.
  - The FSM state enum {S_IDLE, S_HELD}.
  - The one-hot-to-count function used by both this block and testbenches.
- One sub-module is natural: onehot_sync_debounce, covering the 2-flop sync, the stable counter and the d register, parameterised by width and DEBOUNCE_CYCLES.
- The FSM, encode and handshake logic stay in the top.

Test Plan:
- Reset then hold in_onehot=6'b000100 (cnt_ready=1): cnt_valid high on edge 7 with cnt_out=3 for 1 cycle, then cnt_out=0. No second code while the button is held.
- in_onehot=6'b100000 with cnt_ready=0 for 20 cycles: cnt_out=6 and cnt_valid held steady. Then cnt_ready=1 for 1 cycle gives cnt_valid=0 and cnt_out=0.
- in_onehot=6'b000011 stable: err_multi is a single pulse on edge 7, cnt_valid stays 0. After release and a press of 6'b000001, cnt_out=1.
- 2-cycle glitch to 6'b001000, then 0: no cnt_valid, no err_multi, FSM stays S_IDLE.
- Press 6'b000010 (code 2) with cnt_ready=0, release, press 6'b010000: overrun pulses once and cnt_out remains 2.
- Assert rst_n=0 for 1 cycle while cnt_valid=1 and a button is held: all outputs 0 next edge. The held button is re-reported DEBOUNCE_CYCLES+3 edges after reset is released.
